// File: rtl/mean_controller.sv
// Control FSM for the running-mean datapath: sequences clear, accumulate, divide and done.
// Define MEAN_CTRL_WATCHDOG_EN to build the ACC watchdog and the sticky ERR state.
module mean_controller #(
    parameter int DIV_CYCLES  = 1,
    parameter int ACC_TIMEOUT = 300
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       co,
    output logic       enReg,
    output logic       cnten,
    output logic       clear,
    output logic       endiv,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [2:0] state_dbg
);

    // Handshake: start is a level request honoured only in IDLE/ERR; busy spans
    // CLEAR..DONE and done is a single-cycle pulse in the last busy cycle.
`ifdef MEAN_CTRL_WATCHDOG_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACC   = 3'd2,
        S_DIV   = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ACC   = 3'd2,
        S_DIV   = 3'd3,
        S_DONE  = 3'd4
    } state_t;
`endif

    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] div_cnt;
    logic       div_last;

    assign div_last  = (div_cnt == 4'd0);
    assign state_dbg = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            div_cnt <= 4'd0;
        end else begin
            state_q <= state_d;
            // Loaded on the ACC->DIV edge so the first DIV cycle already counts.
            if (state_q == S_ACC && co)
                div_cnt <= DIV_LOAD;
            else if (state_q == S_DIV && !div_last)
                div_cnt <= div_cnt - 4'd1;
        end
    end

`ifdef MEAN_CTRL_WATCHDOG_EN
    localparam logic [9:0] TIMEOUT_LAST = 10'(ACC_TIMEOUT - 1);

    logic [9:0] wd_cnt;
    logic       timeout;

    // wd_cnt holds (ACC cycle number - 1) while in ACC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            wd_cnt <= 10'd0;
        else if (state_q == S_CLEAR)
            wd_cnt <= 10'd0;
        else if (state_q == S_ACC && wd_cnt != 10'h3ff)
            wd_cnt <= wd_cnt + 10'd1;
    end

    assign timeout = (wd_cnt >= TIMEOUT_LAST);
`endif

    always_comb begin
        state_d = state_q;
        enReg   = 1'b0;
        cnten   = 1'b0;
        clear   = 1'b0;
        endiv   = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start)
                    state_d = S_CLEAR;
            end
            S_CLEAR: begin
                clear   = 1'b1;
                busy    = 1'b1;
                state_d = S_ACC;
            end
            S_ACC: begin
                enReg = 1'b1;
                cnten = 1'b1;
                busy  = 1'b1;
                // co beats a simultaneous timeout: the last sample is still valid.
                if (co)
                    state_d = S_DIV;
`ifdef MEAN_CTRL_WATCHDOG_EN
                else if (timeout)
                    state_d = S_ERR;
`endif
            end
            S_DIV: begin
                endiv = 1'b1;
                busy  = 1'b1;
                if (div_last)
                    state_d = S_DONE;
            end
            S_DONE: begin
                done    = 1'b1;
                busy    = 1'b1;
                state_d = S_IDLE;
            end
`ifdef MEAN_CTRL_WATCHDOG_EN
            S_ERR: begin
                err = 1'b1;
                if (start)
                    state_d = S_CLEAR;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mean_controller.sv
// Bench for mean_controller: two instances (DIV_CYCLES=1 and 3) checked cycle by cycle
// against expected output vectors built from the start/co latency rules.
module tb_mean_controller;

    localparam logic [2:0] IDLE_CODE = 3'd0;

    logic clk = 1'b0;
    logic rst;
    logic start1, co1, start3, co3;
    logic enReg1, cnten1, clear1, endiv1, busy1, done1, err1;
    logic enReg3, cnten3, clear3, endiv3, busy3, done3, err3;
    logic [2:0] st1, st3;
    logic [6:0] o1, o3;

    int total = 0;
    int bad   = 0;
    logic [6:0] exp_q1[$];
    logic [6:0] exp_q3[$];

    typedef struct {
        int k;
        bit noise;
        int blen1;
        int blen3;
    } case_t;

    always #5 clk = ~clk;

    mean_controller #(.DIV_CYCLES(1), .ACC_TIMEOUT(300)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .co(co1),
        .enReg(enReg1), .cnten(cnten1), .clear(clear1), .endiv(endiv1),
        .busy(busy1), .done(done1), .err(err1), .state_dbg(st1)
    );

    mean_controller #(.DIV_CYCLES(3), .ACC_TIMEOUT(20)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .co(co3),
        .enReg(enReg3), .cnten(cnten3), .clear(clear3), .endiv(endiv3),
        .busy(busy3), .done(done3), .err(err3), .state_dbg(st3)
    );

    assign o1 = {enReg1, cnten1, clear1, endiv1, busy1, done1, err1};
    assign o3 = {enReg3, cnten3, clear3, endiv3, busy3, done3, err3};

    // Bits: enReg cnten clear endiv busy done err. t=1 is the cycle after start is sampled.
    function automatic logic [6:0] exp_vec(input int t, input int k, input int d);
        if (t == 1)                       return 7'b0010100;
        if (t >= 2 && t <= 1 + k)         return 7'b1100100;
        if (t >= 2 + k && t <= 1 + k + d) return 7'b0001100;
        if (t == 2 + k + d)               return 7'b0000110;
        return 7'b0000000;
    endfunction

    task automatic cmp(input string name, input logic [6:0] act, input logic [6:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic cmp_int(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pop_check(input string tag, input int t);
        logic [6:0] e;
        if (exp_q1.size() == 0 || exp_q3.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s c%0d: expected queue empty", tag, t);
        end else begin
            e = exp_q1.pop_front();
            cmp($sformatf("%s c%0d dut1", tag, t), o1, e);
            e = exp_q3.pop_front();
            cmp($sformatf("%s c%0d dut3", tag, t), o3, e);
        end
    endtask

    // One run: start pulse, co in ACC cycle k, optional random start/co where ignored.
    task automatic drive_run(input int k, input bit use1, input bit use3, input bit noise,
                             input int blen1, input int blen3, input string tag);
        int len;
        int b1;
        int b3;
        logic s;
        logic c;
        len = k + 6;
        b1  = 0;
        b3  = 0;
        for (int t = 1; t <= len; t++) begin
            exp_q1.push_back(use1 ? exp_vec(t, k, 1) : 7'd0);
            exp_q3.push_back(use3 ? exp_vec(t, k, 3) : 7'd0);
        end
        start1 = use1;
        start3 = use3;
        co1    = 1'b0;
        co3    = 1'b0;
        for (int t = 1; t <= len; t++) begin
            @(posedge clk);
            #1;
            s = noise && (t <= k + 2) && ($urandom_range(0, 1) == 1);
            if (t == k + 1)
                c = 1'b1;
            else if (t >= 2 && t <= k)
                c = 1'b0;
            else
                c = noise && ($urandom_range(0, 1) == 1);
            start1 = use1 & s;
            start3 = use3 & s;
            co1    = use1 & c;
            co3    = use3 & c;
            @(negedge clk);
            b1 += int'(busy1);
            b3 += int'(busy3);
            pop_check(tag, t);
        end
        start1 = 1'b0;
        start3 = 1'b0;
        co1    = 1'b0;
        co3    = 1'b0;
        cmp_int({tag, " busy_len dut1"}, b1, blen1);
        cmp_int({tag, " busy_len dut3"}, b3, blen3);
    endtask

    initial begin
        case_t cases[5];
        int r;
        int s;

        cases[0] = '{k: 8,  noise: 1'b0, blen1: 11, blen3: 13};
        cases[1] = '{k: 1,  noise: 1'b0, blen1: 4,  blen3: 6};
        cases[2] = '{k: 3,  noise: 1'b1, blen1: 6,  blen3: 8};
        cases[3] = '{k: 2,  noise: 1'b1, blen1: 5,  blen3: 7};
        cases[4] = '{k: 12, noise: 1'b1, blen1: 15, blen3: 17};

        // Clock/reset
        rst    = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        co1    = 1'b0;
        co3    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        cmp("reset outputs dut1", o1, 7'd0);
        cmp("reset outputs dut3", o3, 7'd0);
        cmp("reset state dut1", {4'd0, st1}, {4'd0, IDLE_CODE});
        cmp("reset state dut3", {4'd0, st3}, {4'd0, IDLE_CODE});
        rst = 1'b0;
        @(negedge clk);
        cmp("idle after reset dut1", o1, 7'd0);
        cmp("idle after reset dut3", o3, 7'd0);

        // Table-driven runs
        for (int i = 0; i < 5; i++)
            drive_run(cases[i].k, 1'b1, 1'b1, cases[i].noise, cases[i].blen1, cases[i].blen3,
                      $sformatf("run%0d", i));

        // Reset asserted in ACC aborts the run without done.
        start1 = 1'b1;
        start3 = 1'b1;
        for (int t = 1; t <= 4; t++) begin
            @(posedge clk);
            #1;
            start1 = 1'b0;
            start3 = 1'b0;
            exp_q1.push_back(exp_vec(t, 5, 1));
            exp_q3.push_back(exp_vec(t, 5, 3));
            @(negedge clk);
            pop_check("pre_abort", t);
        end
        #2;
        rst = 1'b1;
        #1;
        cmp("async reset dut1", o1, 7'd0);
        cmp("async reset dut3", o3, 7'd0);
        cmp("async reset state dut1", {4'd0, st1}, {4'd0, IDLE_CODE});
        cmp("async reset state dut3", {4'd0, st3}, {4'd0, IDLE_CODE});
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int t = 1; t <= 3; t++) begin
            @(negedge clk);
            cmp($sformatf("post_abort c%0d dut1", t), o1, 7'd0);
            cmp($sformatf("post_abort c%0d dut3", t), o3, 7'd0);
            cmp($sformatf("post_abort state c%0d dut1", t), {4'd0, st1}, {4'd0, IDLE_CODE});
        end
        drive_run(4, 1'b1, 1'b1, 1'b0, 7, 9, "after_abort");

        // start held for 40 cycles, 4-sample runs: periods 8 (D=1) and 10 (D=3).
        start1 = 1'b1;
        start3 = 1'b1;
        for (int c = 1; c <= 48; c++) begin
            r = (c - 1) / 8;
            s = 1 + r * 8;
            exp_q1.push_back((s - 1 < 40) ? exp_vec(c - s + 1, 4, 1) : 7'd0);
            r = (c - 1) / 10;
            s = 1 + r * 10;
            exp_q3.push_back((s - 1 < 40) ? exp_vec(c - s + 1, 4, 3) : 7'd0);
            @(posedge clk);
            #1;
            start1 = (c < 40);
            start3 = (c < 40);
            co1    = ((c - 1) % 8 == 4);
            co3    = ((c - 1) % 10 == 4);
            @(negedge clk);
            pop_check("held", c);
        end
        start1 = 1'b0;
        start3 = 1'b0;
        co1    = 1'b0;
        co3    = 1'b0;

`ifdef MEAN_CTRL_WATCHDOG_EN
        // dut3 has ACC_TIMEOUT=20: co never arrives, ERR from the cycle after ACC cycle 20.
        start3 = 1'b1;
        for (int t = 1; t <= 25; t++) begin
            @(posedge clk);
            #1;
            start3 = 1'b0;
            exp_q1.push_back(7'd0);
            if (t <= 21)
                exp_q3.push_back(exp_vec(t, 100, 3));
            else
                exp_q3.push_back(7'b0000001);
            @(negedge clk);
            pop_check("wd_timeout", t);
        end
        drive_run(5, 1'b0, 1'b1, 1'b0, 0, 10, "wd_recover");
        drive_run(20, 1'b0, 1'b1, 1'b0, 0, 25, "wd_co_wins");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
